// File: rtl/hires_fetch_sequencer_if.sv
// Bundle between the hires fetch stage, its video RAM read port and the pixel sequencer.
// The master modport is the fetch stage. The slave modport is the surrounding raster and memory logic.
interface hires_fetch_sequencer_if #(
    parameter int VRAM_AW = 15
);
    logic                fetch_req;
    logic                line_done;
    logic                frame_start;
    logic                display_en;
    logic [2:0]          hires_mode;
    logic [VRAM_AW-1:0]  matrix_base;
    logic [VRAM_AW-1:0]  color_base_addr;
    logic [VRAM_AW-1:0]  char_base;
    logic [VRAM_AW-1:0]  bitmap_base;
    logic [10:0]         cursor_pos;
    logic                cursor_en;
    logic [VRAM_AW-1:0]  vram_addr;
    logic                vram_rd;
    logic [7:0]          vram_data;
    logic [7:0]          hires_pixel_data;
    logic [7:0]          hires_color_data;
    logic                hires_cursor;
    logic [2:0]          hires_rc;
    logic [5:0]          blink_ctr;
    logic                fetch_done;
    logic                fetch_overrun;

    modport master (
        input  fetch_req, line_done, frame_start, display_en, hires_mode,
        input  matrix_base, color_base_addr, char_base, bitmap_base,
        input  cursor_pos, cursor_en, vram_data,
        output vram_addr, vram_rd, hires_pixel_data, hires_color_data,
        output hires_cursor, hires_rc, blink_ctr, fetch_done, fetch_overrun
    );

    modport slave (
        output fetch_req, line_done, frame_start, display_en, hires_mode,
        output matrix_base, color_base_addr, char_base, bitmap_base,
        output cursor_pos, cursor_en, vram_data,
        input  vram_addr, vram_rd, hires_pixel_data, hires_color_data,
        input  hires_cursor, hires_rc, blink_ctr, fetch_done, fetch_overrun
    );
endinterface

// File: rtl/hires_fetch_sequencer.sv
// Hires fetch stage: performs one to three video RAM reads per character slot and delivers the bytes to the pixel sequencer.
// It also maintains the video counter, row counter, framebuffer pointer and blink counter.
module hires_fetch_sequencer #(
    parameter int VRAM_AW      = 15,
    parameter int VRAM_LATENCY = 2
) (
    input logic                    clk_dot4x,
    input logic                    rst,
    hires_fetch_sequencer_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [3:0] LAT_EXTRA = 4'(VRAM_LATENCY - 2);

    logic [2:0]         state;
    logic [2:0]         mode_q;
    logic [1:0]         num_rd;
    logic [1:0]         rd_idx;
    logic [3:0]         lat_cnt;
    logic [7:0]         byte0, byte1, byte2;
    logic [10:0]        vc, vcbase, vc_q;
    logic [2:0]         rc;
    logic [VRAM_AW-1:0] fb_ptr, fb_q;
    logic               line_pend, frame_pend;

    logic [1:0]         req_n, nxt_idx;
    logic [2:0]         sel_mode;
    logic [10:0]        sel_vc;
    logic [VRAM_AW-1:0] sel_fb, nxt_addr, fb_step;
    logic               start, apply_ev, line_ev, frame_ev;

    always_comb begin
        case (bus.hires_mode)
            3'b000:                req_n = 2'd3;
            3'b001, 3'b010, 3'b011: req_n = 2'd2;
            3'b100:                req_n = 2'd1;
            default:               req_n = 2'd0;
        endcase
    end

    assign start = (state == IDLE) && bus.fetch_req && bus.display_en && (req_n != 2'd0);

    // The first read of a slot uses live mode/vc/fb_ptr because they are latched on that same edge.
    always_comb begin
        nxt_idx  = start ? 2'd0 : rd_idx + 2'd1;
        sel_mode = start ? bus.hires_mode : mode_q;
        sel_vc   = start ? vc : vc_q;
        sel_fb   = start ? fb_ptr : fb_q;
        nxt_addr = '0;
        case (sel_mode)
            3'b000: begin
                if (nxt_idx == 2'd0)
                    nxt_addr = bus.matrix_base + VRAM_AW'(sel_vc);
                else if (nxt_idx == 2'd1)
                    nxt_addr = bus.color_base_addr + VRAM_AW'(sel_vc);
                else
                    nxt_addr = bus.char_base + VRAM_AW'({byte0, 3'b000}) + VRAM_AW'(rc);
            end
            3'b001: begin
                if (nxt_idx == 2'd0)
                    nxt_addr = bus.color_base_addr + VRAM_AW'(sel_vc);
                else
                    nxt_addr = bus.bitmap_base + VRAM_AW'({sel_vc, 3'b000}) + VRAM_AW'(rc);
            end
            3'b010, 3'b011: nxt_addr = bus.bitmap_base + sel_fb + VRAM_AW'(nxt_idx);
            3'b100:         nxt_addr = bus.bitmap_base + sel_fb;
            default:        nxt_addr = '0;
        endcase
    end

    // Read sequencing: ISSUE holds the strobe for one clock, then WAIT (more reads follow) or CAPTURE (last read) until the data is valid.
    always_ff @(posedge clk_dot4x) begin
        if (!rst) begin
            state                <= IDLE;
            mode_q               <= '0;
            num_rd               <= '0;
            rd_idx               <= '0;
            lat_cnt              <= '0;
            byte0                <= '0;
            byte1                <= '0;
            byte2                <= '0;
            vc_q                 <= '0;
            fb_q                 <= '0;
            bus.vram_addr        <= '0;
            bus.vram_rd          <= 1'b0;
            bus.hires_pixel_data <= '0;
            bus.hires_color_data <= '0;
            bus.hires_cursor     <= 1'b0;
            bus.hires_rc         <= '0;
            bus.fetch_done       <= 1'b0;
            bus.fetch_overrun    <= 1'b0;
        end else begin
            bus.vram_rd       <= 1'b0;
            bus.fetch_done    <= 1'b0;
            bus.fetch_overrun <= bus.fetch_req && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q        <= bus.hires_mode;
                        vc_q          <= vc;
                        fb_q          <= fb_ptr;
                        num_rd        <= req_n;
                        rd_idx        <= 2'd0;
                        bus.vram_addr <= nxt_addr;
                        bus.vram_rd   <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_EXTRA;
                    state   <= (rd_idx == num_rd - 2'd1) ? CAPTURE : WAIT;
                end
                WAIT, CAPTURE: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        case (rd_idx)
                            2'd0:    byte0 <= bus.vram_data;
                            2'd1:    byte1 <= bus.vram_data;
                            default: byte2 <= bus.vram_data;
                        endcase
                        if (state == WAIT) begin
                            rd_idx        <= nxt_idx;
                            bus.vram_addr <= nxt_addr;
                            bus.vram_rd   <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    case (mode_q)
                        3'b000: begin
                            bus.hires_pixel_data <= byte2;
                            bus.hires_color_data <= byte1;
                        end
                        3'b100: begin
                            bus.hires_pixel_data <= byte0;
                            bus.hires_color_data <= 8'h00;
                        end
                        default: begin
                            bus.hires_pixel_data <= byte1;
                            bus.hires_color_data <= byte0;
                        end
                    endcase
                    bus.hires_rc     <= rc;
                    bus.hires_cursor <= bus.cursor_en && (mode_q == 3'b000) && (vc_q == bus.cursor_pos);
                    bus.fetch_done   <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fb_step  = (mode_q == 3'b100) ? VRAM_AW'(1) :
                      ((mode_q == 3'b010) || (mode_q == 3'b011)) ? VRAM_AW'(2) : '0;
    assign apply_ev = (state == IDLE) || (state == DONE);
    assign line_ev  = (bus.line_done && bus.display_en) || line_pend;
    assign frame_ev = bus.frame_start || frame_pend;

    // Raster events arriving mid-slot are held and then applied on top of the DONE increment, so none are lost.
    always_ff @(posedge clk_dot4x) begin
        if (!rst) begin
            vc            <= '0;
            vcbase        <= '0;
            rc            <= '0;
            fb_ptr        <= '0;
            line_pend     <= 1'b0;
            frame_pend    <= 1'b0;
            bus.blink_ctr <= '0;
        end else begin
            if (bus.frame_start)
                bus.blink_ctr <= bus.blink_ctr + 6'd1;
            if (apply_ev) begin
                line_pend  <= 1'b0;
                frame_pend <= 1'b0;
                if (frame_ev) begin
                    vc     <= '0;
                    vcbase <= '0;
                    rc     <= '0;
                    fb_ptr <= '0;
                end else begin
                    fb_ptr <= (state == DONE) ? fb_ptr + fb_step : fb_ptr;
                    if (line_ev) begin
                        if (rc == 3'd7) begin
                            vcbase <= (state == DONE) ? vc + 11'd1 : vc;
                            vc     <= (state == DONE) ? vc + 11'd1 : vc;
                            rc     <= 3'd0;
                        end else begin
                            vc <= vcbase;
                            rc <= rc + 3'd1;
                        end
                    end else if (state == DONE) begin
                        vc <= vc + 11'd1;
                    end
                end
            end else begin
                if (bus.line_done && bus.display_en)
                    line_pend <= 1'b1;
                if (bus.frame_start)
                    frame_pend <= 1'b1;
            end
        end
    end
endmodule
